// File: rtl/procyon_rob_entry_sf_pkg.sv
// Shared types and constants for the ROB entry slice: slot states, op-type bit
// positions, the CDB channel record and the modulo age helper.
package procyon_rob_entry_sf_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDR_WIDTH    = 32;
  localparam int DEF_CDB_DEPTH     = 2;
  localparam int DEF_ROB_IDX_WIDTH = 5;
  localparam int DEF_RAT_IDX_WIDTH = 5;
  localparam int DEF_EXC_WIDTH     = 4;
  localparam int DEF_OP_IS_WIDTH   = 4;

  // op_is is one-hot; these are the bit positions of each op class
  localparam int OP_IS_OP = 0;
  localparam int OP_IS_LD = 1;
  localparam int OP_IS_ST = 2;
  localparam int OP_IS_JL = 3;

  typedef enum logic [1:0] {
    INVALID     = 2'd0,
    PENDING     = 2'd1,
    LSU_PENDING = 2'd2,
    RETIRABLE   = 2'd3
  } rob_state_t;

  typedef struct packed {
    logic                         en;
    logic                         redirect;
    logic                         exc;
    logic [DEF_EXC_WIDTH-1:0]     exc_cause;
    logic [DEF_DATA_WIDTH-1:0]    data;
    logic [DEF_ROB_IDX_WIDTH-1:0] tag;
  } cdb_chan_t;

  function automatic logic [DEF_ROB_IDX_WIDTH-1:0] rob_age(
    input logic [DEF_ROB_IDX_WIDTH-1:0] tag,
    input logic [DEF_ROB_IDX_WIDTH-1:0] head
  );
    return tag - head;
  endfunction

endpackage

// File: rtl/procyon_rob_entry_sf_if.sv
// Control/data bundle between the ROB array and one ROB slot.
interface procyon_rob_entry_sf_if #(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_CDB_DEPTH     = 2,
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  parameter int OPTN_RAT_IDX_WIDTH = 5,
  parameter int OPTN_EXC_WIDTH     = 4,
  parameter int OPTN_OP_IS_WIDTH   = 4
);
  logic [OPTN_ROB_IDX_WIDTH-1:0]                     i_rob_tag;
  logic [OPTN_ROB_IDX_WIDTH-1:0]                     i_rob_head;
  logic                                              i_redirect;
  logic                                              i_flush_en;
  logic [OPTN_ROB_IDX_WIDTH-1:0]                     i_flush_tag;
  logic [OPTN_CDB_DEPTH-1:0]                         i_cdb_en;
  logic [OPTN_CDB_DEPTH-1:0]                         i_cdb_redirect;
  logic [OPTN_CDB_DEPTH-1:0]                         i_cdb_exc;
  logic [OPTN_CDB_DEPTH-1:0][OPTN_EXC_WIDTH-1:0]     i_cdb_exc_cause;
  logic [OPTN_CDB_DEPTH-1:0][OPTN_DATA_WIDTH-1:0]    i_cdb_data;
  logic [OPTN_CDB_DEPTH-1:0][OPTN_ROB_IDX_WIDTH-1:0] i_cdb_tag;
  logic                                              i_dispatch_en;
  logic [OPTN_OP_IS_WIDTH-1:0]                       i_dispatch_op_is;
  logic [OPTN_ADDR_WIDTH-1:0]                        i_dispatch_pc;
  logic [OPTN_RAT_IDX_WIDTH-1:0]                     i_dispatch_rdst;
  logic [OPTN_DATA_WIDTH-1:0]                        i_dispatch_rdst_data;
  logic                                              i_retire_en;
  logic                                              i_lsu_retire_lq_ack;
  logic                                              i_lsu_retire_sq_ack;
  logic                                              i_lsu_retire_misspeculated;
  logic                                              o_retirable;
  logic                                              o_lsu_pending;
  logic                                              o_valid;
  logic                                              o_rob_entry_redirect;
  logic                                              o_rob_entry_exc;
  logic [OPTN_EXC_WIDTH-1:0]                         o_rob_entry_exc_cause;
  logic [OPTN_DATA_WIDTH-1:0]                        o_rob_entry_data;
  logic [OPTN_RAT_IDX_WIDTH-1:0]                     o_rob_entry_rdst;
  logic [OPTN_OP_IS_WIDTH-1:0]                       o_rob_entry_op_is;
  logic [OPTN_ADDR_WIDTH-1:0]                        o_rob_entry_pc;

  modport master (
    output i_rob_tag, i_rob_head, i_redirect, i_flush_en, i_flush_tag,
           i_cdb_en, i_cdb_redirect, i_cdb_exc, i_cdb_exc_cause, i_cdb_data, i_cdb_tag,
           i_dispatch_en, i_dispatch_op_is, i_dispatch_pc, i_dispatch_rdst, i_dispatch_rdst_data,
           i_retire_en, i_lsu_retire_lq_ack, i_lsu_retire_sq_ack, i_lsu_retire_misspeculated,
    input  o_retirable, o_lsu_pending, o_valid, o_rob_entry_redirect, o_rob_entry_exc,
           o_rob_entry_exc_cause, o_rob_entry_data, o_rob_entry_rdst, o_rob_entry_op_is, o_rob_entry_pc
  );

  modport slave (
    input  i_rob_tag, i_rob_head, i_redirect, i_flush_en, i_flush_tag,
           i_cdb_en, i_cdb_redirect, i_cdb_exc, i_cdb_exc_cause, i_cdb_data, i_cdb_tag,
           i_dispatch_en, i_dispatch_op_is, i_dispatch_pc, i_dispatch_rdst, i_dispatch_rdst_data,
           i_retire_en, i_lsu_retire_lq_ack, i_lsu_retire_sq_ack, i_lsu_retire_misspeculated,
    output o_retirable, o_lsu_pending, o_valid, o_rob_entry_redirect, o_rob_entry_exc,
           o_rob_entry_exc_cause, o_rob_entry_data, o_rob_entry_rdst, o_rob_entry_op_is, o_rob_entry_pc
  );
endinterface

// File: rtl/procyon_rob_entry_sf_age_cmp.sv
// Modulo age compare against the ROB head: a is younger than b when it sits
// further from head, so wrap-around of the tag space is handled naturally.
module procyon_rob_entry_sf_age_cmp #(
  parameter int OPTN_TAG_WIDTH = 5
) (
  input  logic [OPTN_TAG_WIDTH-1:0] head,
  input  logic [OPTN_TAG_WIDTH-1:0] a,
  input  logic [OPTN_TAG_WIDTH-1:0] b,
  output logic                      a_younger_than_b
);
  logic [OPTN_TAG_WIDTH-1:0] age_a_s;
  logic [OPTN_TAG_WIDTH-1:0] age_b_s;

  assign age_a_s          = a - head;
  assign age_b_s          = b - head;
  assign a_younger_than_b = (age_a_s > age_b_s);
endmodule

// File: rtl/procyon_rob_entry_sf.sv
// One reorder-buffer slot: dispatch -> CDB writeback -> optional LSU ack -> retire,
// with full redirect and age-based selective flush.
module procyon_rob_entry_sf
  import procyon_rob_entry_sf_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int OPTN_ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int OPTN_CDB_DEPTH     = DEF_CDB_DEPTH,
  parameter int OPTN_ROB_IDX_WIDTH = DEF_ROB_IDX_WIDTH,
  parameter int OPTN_RAT_IDX_WIDTH = DEF_RAT_IDX_WIDTH,
  parameter int OPTN_EXC_WIDTH     = DEF_EXC_WIDTH,
  parameter int OPTN_OP_IS_WIDTH   = DEF_OP_IS_WIDTH
) (
  input logic                   clk,
  input logic                   rst,
  procyon_rob_entry_sf_if.slave rob_if
);
  rob_state_t                    state_r;
  rob_state_t                    state_next_s;
  logic                          valid_r;
  logic                          retirable_r;
  logic                          lsu_pending_r;
  logic                          redirect_r;
  logic                          exc_r;
  logic [OPTN_EXC_WIDTH-1:0]     exc_cause_r;
  logic [OPTN_DATA_WIDTH-1:0]    data_r;
  logic [OPTN_RAT_IDX_WIDTH-1:0] rdst_r;
  logic [OPTN_OP_IS_WIDTH-1:0]   op_is_r;
  logic [OPTN_ADDR_WIDTH-1:0]    pc_r;

  logic                          younger_s;
  logic                          kill_s;
  logic                          lsu_ack_s;
  logic                          cdb_match_s;
  logic                          cdb_redirect_s;
  logic                          cdb_exc_s;
  logic [OPTN_EXC_WIDTH-1:0]     cdb_exc_cause_s;
  logic [OPTN_DATA_WIDTH-1:0]    cdb_data_s;

  procyon_rob_entry_sf_age_cmp #(
    .OPTN_TAG_WIDTH (OPTN_ROB_IDX_WIDTH)
  ) age_cmp (
    .head             (rob_if.i_rob_head),
    .a                (rob_if.i_rob_tag),
    .b                (rob_if.i_flush_tag),
    .a_younger_than_b (younger_s)
  );

  assign kill_s    = rob_if.i_redirect | (rob_if.i_flush_en & younger_s);
  assign lsu_ack_s = (rob_if.i_lsu_retire_lq_ack & op_is_r[OP_IS_LD]) |
                     (rob_if.i_lsu_retire_sq_ack & op_is_r[OP_IS_ST]);

  // Select the matching CDB channel; scanning upward lets the highest index win
  always_comb begin
    cdb_match_s     = 1'b0;
    cdb_redirect_s  = 1'b0;
    cdb_exc_s       = 1'b0;
    cdb_exc_cause_s = '0;
    cdb_data_s      = '0;
    for (int k = 0; k < OPTN_CDB_DEPTH; k++) begin
      if (rob_if.i_cdb_en[k] && (rob_if.i_cdb_tag[k] == rob_if.i_rob_tag) && (state_r == PENDING)) begin
        cdb_match_s     = 1'b1;
        cdb_redirect_s  = rob_if.i_cdb_redirect[k];
        cdb_exc_s       = rob_if.i_cdb_exc[k];
        cdb_exc_cause_s = rob_if.i_cdb_exc_cause[k];
        cdb_data_s      = rob_if.i_cdb_data[k];
      end else begin
        cdb_match_s     = cdb_match_s;
      end
    end
  end

  // Next-state logic; a kill overrides every other event
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      INVALID: begin
        if (rob_if.i_dispatch_en) state_next_s = PENDING;
        else                      state_next_s = INVALID;
      end
      PENDING: begin
        if (cdb_match_s) begin
          if (op_is_r[OP_IS_LD] || op_is_r[OP_IS_ST]) state_next_s = LSU_PENDING;
          else                                        state_next_s = RETIRABLE;
        end else begin
          state_next_s = PENDING;
        end
      end
      LSU_PENDING: begin
        if (lsu_ack_s) state_next_s = RETIRABLE;
        else           state_next_s = LSU_PENDING;
      end
      RETIRABLE: begin
        if (rob_if.i_retire_en) state_next_s = INVALID;
        else                    state_next_s = RETIRABLE;
      end
      default: state_next_s = INVALID;
    endcase
    if (kill_s) state_next_s = INVALID;
    else        state_next_s = state_next_s;
  end

  // State register and the status flags decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= INVALID;
      valid_r       <= 1'b0;
      retirable_r   <= 1'b0;
      lsu_pending_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      valid_r       <= (state_next_s != INVALID);
      retirable_r   <= (state_next_s == RETIRABLE);
      lsu_pending_r <= (state_next_s == LSU_PENDING);
    end
  end

  // Entry fields; a killed entry keeps its stale fields behind o_valid=0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_r  <= 1'b0;
      exc_r       <= 1'b0;
      exc_cause_r <= '0;
      data_r      <= '0;
      rdst_r      <= '0;
      op_is_r     <= '0;
      pc_r        <= '0;
    end else if (!kill_s) begin
      case (state_r)
        INVALID: begin
          if (rob_if.i_dispatch_en) begin
            op_is_r     <= rob_if.i_dispatch_op_is;
            pc_r        <= rob_if.i_dispatch_pc;
            rdst_r      <= rob_if.i_dispatch_rdst;
            data_r      <= rob_if.i_dispatch_rdst_data;
            redirect_r  <= 1'b0;
            exc_r       <= 1'b0;
            exc_cause_r <= '0;
          end
        end
        PENDING: begin
          if (cdb_match_s) begin
            // jump-and-link ops return their target on the data bus
            if (op_is_r[OP_IS_JL]) pc_r   <= cdb_data_s[OPTN_ADDR_WIDTH-1:0];
            else                   data_r <= cdb_data_s;
            redirect_r  <= cdb_redirect_s;
            exc_r       <= cdb_exc_s;
            exc_cause_r <= cdb_exc_cause_s;
          end
        end
        LSU_PENDING: begin
          if (rob_if.i_lsu_retire_lq_ack && op_is_r[OP_IS_LD]) begin
            redirect_r <= rob_if.i_lsu_retire_misspeculated;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rob_if.o_valid               = valid_r;
  assign rob_if.o_retirable           = retirable_r;
  assign rob_if.o_lsu_pending         = lsu_pending_r;
  assign rob_if.o_rob_entry_redirect  = redirect_r;
  assign rob_if.o_rob_entry_exc       = exc_r;
  assign rob_if.o_rob_entry_exc_cause = exc_cause_r;
  assign rob_if.o_rob_entry_data      = data_r;
  assign rob_if.o_rob_entry_rdst      = rdst_r;
  assign rob_if.o_rob_entry_op_is     = op_is_r;
  assign rob_if.o_rob_entry_pc        = pc_r;
endmodule

// File: tb/tb_procyon_rob_entry_sf.sv
// Directed bench for one ROB slot: a cycle-by-cycle vector table plus a
// hand-written asynchronous-reset sequence.
module tb_procyon_rob_entry_sf;
  import procyon_rob_entry_sf_pkg::*;

  localparam logic [3:0] OP_ALU = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0100;
  localparam logic [3:0] OP_JL  = 4'b1000;

  typedef struct packed {
    logic        valid;
    logic        retirable;
    logic        lsu_pending;
    logic        redirect;
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] data;
    logic [31:0] pc;
    logic [4:0]  rdst;
    logic [3:0]  op_is;
  } exp_t;

  typedef struct {
    string           name;
    logic [4:0]      tag;
    logic [4:0]      head;
    logic            redirect;
    logic            flush_en;
    logic [4:0]      flush_tag;
    cdb_chan_t [1:0] cdb;
    logic            disp_en;
    logic [3:0]      op;
    logic [31:0]     pc;
    logic [4:0]      rdst;
    logic [31:0]     rdata;
    logic            retire_en;
    logic            lq_ack;
    logic            sq_ack;
    logic            misspec;
    exp_t            exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;
  vec_t v;
  exp_t e;
  vec_t vecs[$];

  procyon_rob_entry_sf_if rob_if ();

  procyon_rob_entry_sf dut (
    .clk    (clk),
    .rst    (rst),
    .rob_if (rob_if)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic [4:0] tag, input logic [4:0] head);
    vec_t r;
    r.name = name;      r.tag = tag;         r.head = head;
    r.redirect = 1'b0;  r.flush_en = 1'b0;   r.flush_tag = 5'd0;
    r.cdb = '0;         r.disp_en = 1'b0;    r.op = 4'd0;
    r.pc = 32'd0;       r.rdst = 5'd0;       r.rdata = 32'd0;
    r.retire_en = 1'b0; r.lq_ack = 1'b0;     r.sq_ack = 1'b0;
    r.misspec = 1'b0;   r.exp = '0;
    return r;
  endfunction

  task automatic vdisp(input logic [3:0] op, input logic [31:0] pc, input logic [4:0] rdst, input logic [31:0] d);
    v.disp_en = 1'b1; v.op = op; v.pc = pc; v.rdst = rdst; v.rdata = d;
  endtask

  task automatic vcdb(input int k, input logic [4:0] tag, input logic [31:0] d,
                      input logic redir, input logic exc, input logic [3:0] cause);
    v.cdb[k] = '{1'b1, redir, exc, cause, d, tag};
  endtask

  task automatic vflush(input logic [4:0] ftag);
    v.flush_en = 1'b1; v.flush_tag = ftag;
  endtask

  task automatic set_st(input rob_state_t s);
    e.valid = (s != INVALID); e.retirable = (s == RETIRABLE); e.lsu_pending = (s == LSU_PENDING);
  endtask

  task automatic set_fields(input logic [3:0] op, input logic [31:0] pc, input logic [4:0] rdst, input logic [31:0] d);
    e.op_is = op; e.pc = pc; e.rdst = rdst; e.data = d; e.redirect = 1'b0; e.exc = 1'b0; e.cause = 4'd0;
  endtask

  task automatic push();
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t a);
    rob_if.i_rob_tag   = a.tag;
    rob_if.i_rob_head  = a.head;
    rob_if.i_redirect  = a.redirect;
    rob_if.i_flush_en  = a.flush_en;
    rob_if.i_flush_tag = a.flush_tag;
    for (int k = 0; k < 2; k++) begin
      rob_if.i_cdb_en[k]        = a.cdb[k].en;
      rob_if.i_cdb_redirect[k]  = a.cdb[k].redirect;
      rob_if.i_cdb_exc[k]       = a.cdb[k].exc;
      rob_if.i_cdb_exc_cause[k] = a.cdb[k].exc_cause;
      rob_if.i_cdb_data[k]      = a.cdb[k].data;
      rob_if.i_cdb_tag[k]       = a.cdb[k].tag;
    end
    rob_if.i_dispatch_en              = a.disp_en;
    rob_if.i_dispatch_op_is           = a.op;
    rob_if.i_dispatch_pc              = a.pc;
    rob_if.i_dispatch_rdst            = a.rdst;
    rob_if.i_dispatch_rdst_data       = a.rdata;
    rob_if.i_retire_en                = a.retire_en;
    rob_if.i_lsu_retire_lq_ack        = a.lq_ack;
    rob_if.i_lsu_retire_sq_ack        = a.sq_ack;
    rob_if.i_lsu_retire_misspeculated = a.misspec;
  endtask

  task automatic check(input string name, input exp_t want);
    exp_t got;
    got.valid       = rob_if.o_valid;
    got.retirable   = rob_if.o_retirable;
    got.lsu_pending = rob_if.o_lsu_pending;
    got.redirect    = rob_if.o_rob_entry_redirect;
    got.exc         = rob_if.o_rob_entry_exc;
    got.cause       = rob_if.o_rob_entry_exc_cause;
    got.data        = rob_if.o_rob_entry_data;
    got.pc          = rob_if.o_rob_entry_pc;
    got.rdst        = rob_if.o_rob_entry_rdst;
    got.op_is       = rob_if.o_rob_entry_op_is;
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got v/r/l/rd/x=%b%b%b%b%b cause=%h data=%h pc=%h rdst=%0d op=%b, expected v/r/l/rd/x=%b%b%b%b%b cause=%h data=%h pc=%h rdst=%0d op=%b",
               name, got.valid, got.retirable, got.lsu_pending, got.redirect, got.exc, got.cause,
               got.data, got.pc, got.rdst, got.op_is,
               want.valid, want.retirable, want.lsu_pending, want.redirect, want.exc, want.cause,
               want.data, want.pc, want.rdst, want.op_is);
    end
  endtask

  initial begin
    apply(mk("idle", 5'd0, 5'd0));
    #12;
    check("reset_state", '0);
    @(negedge clk);
    rst = 1'b0;

    e = '0;
    v = mk("alu_disp", 5'd3, 5'd0); vdisp(OP_ALU, 32'h100, 5'd4, 32'h11);
    set_fields(OP_ALU, 32'h100, 5'd4, 32'h11); set_st(PENDING); push();
    v = mk("alu_cdb", 5'd3, 5'd0); vcdb(0, 5'd3, 32'hDEAD, 1'b0, 1'b0, 4'h0);
    e.data = 32'hDEAD; set_st(RETIRABLE); push();
    v = mk("alu_retire", 5'd3, 5'd0); v.retire_en = 1'b1; set_st(INVALID); push();

    v = mk("ld_disp", 5'd5, 5'd0); vdisp(OP_LD, 32'h200, 5'd6, 32'h0);
    set_fields(OP_LD, 32'h200, 5'd6, 32'h0); set_st(PENDING); push();
    v = mk("ld_cdb", 5'd5, 5'd0); vcdb(1, 5'd5, 32'h55, 1'b0, 1'b0, 4'h0);
    e.data = 32'h55; set_st(LSU_PENDING); push();
    v = mk("ld_sq_ack_ignored", 5'd5, 5'd0); v.sq_ack = 1'b1; push();
    v = mk("ld_lq_ack_misspec", 5'd5, 5'd0); v.lq_ack = 1'b1; v.misspec = 1'b1;
    e.redirect = 1'b1; set_st(RETIRABLE); push();
    v = mk("ld_retire", 5'd5, 5'd0); v.retire_en = 1'b1; set_st(INVALID); push();

    v = mk("jl_disp", 5'd2, 5'd0); vdisp(OP_JL, 32'h300, 5'd1, 32'h77);
    set_fields(OP_JL, 32'h300, 5'd1, 32'h77); set_st(PENDING); push();
    v = mk("jl_cdb", 5'd2, 5'd0); vcdb(0, 5'd2, 32'h1000, 1'b1, 1'b0, 4'h0);
    e.pc = 32'h1000; e.redirect = 1'b1; set_st(RETIRABLE); push();
    v = mk("jl_retire", 5'd2, 5'd0); v.retire_en = 1'b1; set_st(INVALID); push();

    v = mk("dual_disp", 5'd7, 5'd0); vdisp(OP_ALU, 32'h400, 5'd2, 32'h0);
    set_fields(OP_ALU, 32'h400, 5'd2, 32'h0); set_st(PENDING); push();
    v = mk("cdb_other_tag", 5'd7, 5'd0); vcdb(0, 5'd8, 32'hBAD, 1'b1, 1'b1, 4'h3); push();
    v = mk("dual_cdb", 5'd7, 5'd0);
    vcdb(0, 5'd7, 32'hA, 1'b0, 1'b0, 4'h0); vcdb(1, 5'd7, 32'hB0, 1'b0, 1'b1, 4'hB);
    e.data = 32'hB0; e.exc = 1'b1; e.cause = 4'hB; set_st(RETIRABLE); push();
    v = mk("cdb_in_retirable", 5'd7, 5'd0); vcdb(0, 5'd7, 32'h99, 1'b1, 1'b0, 4'h0); push();
    v = mk("dual_retire", 5'd7, 5'd0); v.retire_en = 1'b1; set_st(INVALID); push();

    // tag 1 with head 30: ages are tag=3, flush 1->3, 2->4, 31->1, 0->2, 30->0
    v = mk("wrap_disp", 5'd1, 5'd30); vdisp(OP_ALU, 32'h500, 5'd3, 32'h5);
    set_fields(OP_ALU, 32'h500, 5'd3, 32'h5); set_st(PENDING); push();
    v = mk("flush_tag1_keeps", 5'd1, 5'd30); vflush(5'd1); push();
    v = mk("flush_tag2_keeps", 5'd1, 5'd30); vflush(5'd2); push();
    v = mk("flush_tag31_kills", 5'd1, 5'd30); vflush(5'd31); set_st(INVALID); push();
    v = mk("wrap_disp2", 5'd1, 5'd30); vdisp(OP_ALU, 32'h600, 5'd3, 32'h6);
    set_fields(OP_ALU, 32'h600, 5'd3, 32'h6); set_st(PENDING); push();
    v = mk("flush_tag0_kills", 5'd1, 5'd30); vflush(5'd0); set_st(INVALID); push();
    v = mk("wrap_disp3", 5'd1, 5'd30); vdisp(OP_ALU, 32'h700, 5'd3, 32'h7);
    set_fields(OP_ALU, 32'h700, 5'd3, 32'h7); set_st(PENDING); push();
    v = mk("flush_head_kills", 5'd1, 5'd30); vflush(5'd30); set_st(INVALID); push();
    v = mk("head_disp", 5'd30, 5'd30); vdisp(OP_ALU, 32'h800, 5'd9, 32'h8);
    set_fields(OP_ALU, 32'h800, 5'd9, 32'h8); set_st(PENDING); push();
    v = mk("flush_self_keeps", 5'd30, 5'd30); vflush(5'd30); push();
    v = mk("retire_in_pending_ignored", 5'd30, 5'd30); v.retire_en = 1'b1; push();
    v = mk("disp_in_pending_ignored", 5'd30, 5'd30); vdisp(OP_LD, 32'h900, 5'd10, 32'h9); push();
    v = mk("redirect_kills", 5'd30, 5'd30); v.redirect = 1'b1; set_st(INVALID); push();
    v = mk("disp_with_redirect", 5'd30, 5'd30); vdisp(OP_LD, 32'h900, 5'd10, 32'h9);
    v.redirect = 1'b1; push();

    v = mk("st_disp", 5'd4, 5'd0); vdisp(OP_ST, 32'hA00, 5'd0, 32'h44);
    set_fields(OP_ST, 32'hA00, 5'd0, 32'h44); set_st(PENDING); push();
    v = mk("st_cdb", 5'd4, 5'd0); vcdb(1, 5'd4, 32'h88, 1'b0, 1'b0, 4'h0);
    e.data = 32'h88; set_st(LSU_PENDING); push();
    v = mk("st_lq_ack_ignored", 5'd4, 5'd0); v.lq_ack = 1'b1; v.misspec = 1'b1; push();
    v = mk("st_sq_ack", 5'd4, 5'd0); v.sq_ack = 1'b1; set_st(RETIRABLE); push();
    v = mk("st_retire", 5'd4, 5'd0); v.retire_en = 1'b1; set_st(INVALID); push();

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].exp);
    end

    // Asynchronous reset while the entry waits on the LSU
    @(negedge clk);
    v = mk("rst_ld_disp", 5'd9, 5'd0); vdisp(OP_LD, 32'hC00, 5'd12, 32'h3); apply(v);
    @(posedge clk); #1;
    set_fields(OP_LD, 32'hC00, 5'd12, 32'h3); set_st(PENDING);
    check("rst_ld_disp", e);
    @(negedge clk);
    v = mk("rst_ld_cdb", 5'd9, 5'd0); vcdb(0, 5'd9, 32'h66, 1'b0, 1'b1, 4'h2); apply(v);
    @(posedge clk); #1;
    e.data = 32'h66; e.exc = 1'b1; e.cause = 4'h2; set_st(LSU_PENDING);
    check("rst_ld_lsu_pending", e);
    @(negedge clk);
    apply(mk("idle", 5'd9, 5'd0));
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_lsu_pending", '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("after_rst_idle", '0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
